// File: rtl/dmem_arbiter_pkg.sv
// Shared constants and types for the data-memory arbiter.
// Address layout: [12:10] bank, [9:0] word offset.
package dmem_arbiter_pkg;

    localparam int ADDR_W   = 13;
    localparam int DATA_W   = 32;
    localparam int BANK_MSB = 12;
    localparam int BANK_LSB = 10;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester and DMEM pin bundle for the arbiter.
// slave = arbiter side, master = requesters plus memory.
interface dmem_arbiter_if;
    import dmem_arbiter_pkg::*;

    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              ack0;
    logic              ack1;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;
    logic              busy;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data_in;
    logic              mem_read_write;
    logic [DATA_W-1:0] mem_dataOut;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  mem_dataOut,
        output ack0, ack1, rdata0, rdata1, busy,
        output mem_address, mem_data_in, mem_read_write
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        output mem_dataOut,
        input  ack0, ack1, rdata0, rdata1, busy,
        input  mem_address, mem_data_in, mem_read_write
    );

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; last_grant resets to 1
// so port 0 wins the first tie.
module rr_arb2 (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output logic [1:0] gnt_o
);

    logic last_q;
    logic last_d;

    always_comb begin
        gnt_o[0] = req_i[0] & (~req_i[1] | last_q);
        gnt_o[1] = req_i[1] & (~req_i[0] | ~last_q);
        last_d   = last_q;
        if (advance_i && (|req_i)) begin
            last_d = gnt_o[1];
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port DMEM between the LSU (port 0) and
// the loader/DMA (port 1); one access in flight at a time.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int READ_LAT = 1
) (
    input  logic           clock,
    input  logic           reset,
    dmem_arbiter_if.slave  bus
);

    localparam int CNT_W = $clog2(READ_LAT) + 1;

    state_e            state_q, state_d;
    logic              gnt_q, gnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic              ack0_q, ack0_d;
    logic              ack1_q, ack1_d;
    logic [1:0]        gnt;
    logic              advance;

    rr_arb2 u_arb (
        .clock_i   (clock),
        .reset_i   (reset),
        .req_i     ({bus.req1, bus.req0}),
        .advance_i (advance),
        .gnt_o     (gnt)
    );

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        advance  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.req0 || bus.req1) begin
                    advance = 1'b1;
                    gnt_d   = gnt[1] & ~gnt[0];
                    we_d    = gnt_d ? bus.we1    : bus.we0;
                    addr_d  = gnt_d ? bus.addr1  : bus.addr0;
                    wdata_d = gnt_d ? bus.wdata1 : bus.wdata0;
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (we_q == RW_WRITE) begin
                    state_d = S_RESP;
                    ack0_d  = ~gnt_q;
                    ack1_d  = gnt_q;
                end else begin
                    state_d = S_WAIT;
                    cnt_d   = CNT_W'(READ_LAT - 1);
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    if (gnt_q) begin
                        rdata1_d = bus.mem_dataOut;
                    end else begin
                        rdata0_d = bus.mem_dataOut;
                    end
                    state_d = S_RESP;
                    ack0_d  = ~gnt_q;
                    ack1_d  = gnt_q;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            gnt_q    <= 1'b0;
            we_q     <= RW_READ;
            addr_q   <= '0;
            wdata_q  <= '0;
            cnt_q    <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
        end
    end

    // Address/data only change on a grant, so the pins stay quiet elsewhere.
    assign bus.ack0           = ack0_q;
    assign bus.ack1           = ack1_q;
    assign bus.rdata0         = rdata0_q;
    assign bus.rdata1         = rdata1_q;
    assign bus.busy           = (state_q != S_IDLE);
    assign bus.mem_address    = addr_q;
    assign bus.mem_data_in    = wdata_q;
    assign bus.mem_read_write = (state_q == S_ACCESS) && (we_q == RW_WRITE);

endmodule
